// File: rtl/core_io_bridge.sv
// core_io_bridge: writeback-snoop bridge with an outbound FWFT FIFO and an inbound skid register.
// Ports:
//    clock, reset            - core clock, synchronous active-high reset
//    wb_*                    - writeback snoop (strobe, destination register, data)
//    to_peripheral_*         - outbound valid/ready channel: head data, register index, core ID
//    stall_out               - stall request while too few free FIFO slots remain
//    from_peripheral*        - inbound channel code, data, strobe and ready
//    in_valid/chan/data      - held inbound word; in_consume releases it
//    fifo_count, drop_count, overflow - occupancy, saturating drop counter, sticky drop flag
module core_io_bridge #(
   parameter int CORE          = 0,
   parameter int DATA_WIDTH    = 32,
   parameter int REG_LO        = 10,
   parameter int REG_HI        = 17,
   parameter int FIFO_DEPTH    = 4,
   parameter int STALL_MARGIN  = 2,
   parameter int STALL_ON_FULL = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          wb_write,
   input  logic [4:0]                    wb_reg,
   input  logic [DATA_WIDTH-1:0]         wb_data,
   output logic                          to_peripheral_valid,
   input  logic                          to_peripheral_ready,
   output logic [DATA_WIDTH-1:0]         to_peripheral_data,
   output logic [4:0]                    to_peripheral_reg,
   output logic [7:0]                    to_peripheral_core,
   output logic                          stall_out,
   input  logic [1:0]                    from_peripheral,
   input  logic [31:0]                   from_peripheral_data,
   input  logic                          from_peripheral_valid,
   output logic                          from_peripheral_ready,
   output logic                          in_valid,
   output logic [1:0]                    in_chan,
   output logic [31:0]                   in_data,
   input  logic                          in_consume,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [15:0]                   drop_count,
   output logic                          overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("core_io_bridge: FIFO_DEPTH must be a power of two >= 2");
   end
   if ((REG_LO < 1) || (REG_LO > REG_HI) || (REG_HI > 31)) begin : g_bad_window
      $error("core_io_bridge: register window must satisfy 1 <= REG_LO <= REG_HI <= 31");
   end
   if ((STALL_MARGIN < 1) || (STALL_MARGIN > FIFO_DEPTH - 1)) begin : g_bad_margin
      $error("core_io_bridge: STALL_MARGIN must be in 1..FIFO_DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
   logic [4:0]            mem_reg_q  [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [15:0]           drop_q, drop_d;
   logic                  ovf_q, ovf_d;
   logic                  in_valid_q, in_valid_d;
   logic [1:0]            in_chan_q;
   logic [31:0]           in_data_q;
   logic                  push, pop, full, push_ok, drop, accept;

   always_comb begin
      push     = wb_write && (wb_reg != 5'd0) && (wb_reg >= 5'(REG_LO)) && (wb_reg <= 5'(REG_HI));
      pop      = (count_q != '0) && to_peripheral_ready;
      full     = count_q == CW'(FIFO_DEPTH);
      // When full, a same-cycle pop frees the slot the push needs.
      push_ok  = push && (!full || pop);
      drop     = push && full && !pop;
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push_ok) - CW'(pop);
      drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      ovf_d    = ovf_q || drop;
      accept   = from_peripheral_valid && from_peripheral_ready;
      in_valid_d = accept ? 1'b1 : (in_consume ? 1'b0 : in_valid_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_reg_q[i]  <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_q     <= '0;
         ovf_q      <= 1'b0;
         in_valid_q <= 1'b0;
         in_chan_q  <= '0;
         in_data_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_data_q[wr_ptr_q] <= wb_data;
            mem_reg_q[wr_ptr_q]  <= wb_reg;
         end
         if (accept) begin
            in_chan_q <= from_peripheral;
            in_data_q <= from_peripheral_data;
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         ovf_q      <= ovf_d;
         in_valid_q <= in_valid_d;
      end
   end

   assign to_peripheral_valid   = count_q != '0;
   assign to_peripheral_data    = mem_data_q[rd_ptr_q];
   assign to_peripheral_reg     = mem_reg_q[rd_ptr_q];
   assign to_peripheral_core    = 8'(CORE);
   // Based on the registered count only, so the margin must absorb in-flight writebacks.
   assign stall_out             = (STALL_ON_FULL != 0) && ((CW'(FIFO_DEPTH) - count_q) < CW'(STALL_MARGIN));
   assign from_peripheral_ready = !in_valid_q || in_consume;
   assign in_valid              = in_valid_q;
   assign in_chan               = in_chan_q;
   assign in_data               = in_data_q;
   assign fifo_count            = count_q;
   assign drop_count            = drop_q;
   assign overflow              = ovf_q;
endmodule

// File: tb/tb_core_io_bridge.sv
// tb_core_io_bridge: directed self-checking bench for core_io_bridge (stalling and lossy configurations).
module tb_core_io_bridge;
   logic        clock = 1'b0;
   logic        reset;
   logic        wb_write, tp_ready, fp_valid, in_consume;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data, fp_data;
   logic [1:0]  fp_chan;
   logic        tp_valid, stall_out, fp_ready, in_valid, overflow;
   logic [31:0] tp_data, in_data;
   logic [4:0]  tp_reg;
   logic [7:0]  tp_core;
   logic [1:0]  in_chan;
   logic [2:0]  fifo_count;
   logic [15:0] drop_count;

   logic        l_wb_write;
   logic [4:0]  l_wb_reg;
   logic [31:0] l_wb_data;
   logic        l_tp_valid, l_stall, l_fp_ready, l_in_valid, l_overflow;
   logic [31:0] l_tp_data, l_in_data;
   logic [4:0]  l_tp_reg;
   logic [7:0]  l_tp_core;
   logic [1:0]  l_in_chan;
   logic [1:0]  l_count;
   logic [15:0] l_drop;

   int checks = 0;
   int failures = 0;
   int stall_seen = 0;

   always #5 clock = ~clock;

   core_io_bridge #(.CORE(8'h3A)) u_dut (
      .clock(clock), .reset(reset),
      .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
      .to_peripheral_valid(tp_valid), .to_peripheral_ready(tp_ready),
      .to_peripheral_data(tp_data), .to_peripheral_reg(tp_reg), .to_peripheral_core(tp_core),
      .stall_out(stall_out),
      .from_peripheral(fp_chan), .from_peripheral_data(fp_data),
      .from_peripheral_valid(fp_valid), .from_peripheral_ready(fp_ready),
      .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data), .in_consume(in_consume),
      .fifo_count(fifo_count), .drop_count(drop_count), .overflow(overflow)
   );

   core_io_bridge #(.FIFO_DEPTH(2), .STALL_MARGIN(1), .STALL_ON_FULL(0)) u_lossy (
      .clock(clock), .reset(reset),
      .wb_write(l_wb_write), .wb_reg(l_wb_reg), .wb_data(l_wb_data),
      .to_peripheral_valid(l_tp_valid), .to_peripheral_ready(1'b0),
      .to_peripheral_data(l_tp_data), .to_peripheral_reg(l_tp_reg), .to_peripheral_core(l_tp_core),
      .stall_out(l_stall),
      .from_peripheral(2'b00), .from_peripheral_data(32'h0),
      .from_peripheral_valid(1'b0), .from_peripheral_ready(l_fp_ready),
      .in_valid(l_in_valid), .in_chan(l_in_chan), .in_data(l_in_data), .in_consume(1'b0),
      .fifo_count(l_count), .drop_count(l_drop), .overflow(l_overflow)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      wb_write = 1'b1;
      wb_reg   = r;
      wb_data  = d;
      tick();
      wb_write = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wb_write = 0; wb_reg = 0; wb_data = 0; tp_ready = 0;
      fp_valid = 0; fp_chan = 0; fp_data = 0; in_consume = 0;
      l_wb_write = 0; l_wb_reg = 0; l_wb_data = 0;
      tick(); tick();
      chk("rst_count", fifo_count, 0);
      chk("rst_valid", tp_valid, 0);
      chk("rst_data", tp_data, 0);
      chk("rst_reg", tp_reg, 0);
      chk("rst_core", tp_core, 8'h3A);
      chk("rst_stall", stall_out, 0);
      chk("rst_fp_ready", fp_ready, 1);
      chk("rst_in_valid", in_valid, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;

      wb(5'd10, 32'h11);
      chk("lat_valid", tp_valid, 1);
      chk("lat_data", tp_data, 32'h11);
      wb(5'd11, 32'h22);
      wb(5'd5, 32'h33);
      wb(5'd0, 32'h99);
      chk("cap_count", fifo_count, 2);
      chk("cap_head_reg", tp_reg, 10);
      chk("cap_head_data", tp_data, 32'h11);
      chk("cap_stall2", stall_out, 0);

      wb(5'd17, 32'h55);
      wb(5'd18, 32'h77);
      wb(5'd9, 32'h78);
      chk("win_count", fifo_count, 3);
      chk("stall_at3", stall_out, 1);

      tp_ready = 1'b1; tick(); tp_ready = 1'b0;
      chk("pop_head_reg", tp_reg, 11);
      chk("pop_head_data", tp_data, 32'h22);
      chk("pop_count", fifo_count, 2);
      chk("pop_stall", stall_out, 0);
      tick();
      chk("hold_reg", tp_reg, 11);
      chk("hold_valid", tp_valid, 1);

      wb(5'd15, 32'hA1);
      wb(5'd16, 32'hA2);
      chk("fill_count", fifo_count, 4);
      chk("fill_stall", stall_out, 1);
      wb(5'd12, 32'h44);
      chk("drop_cnt", drop_count, 1);
      chk("drop_ovf", overflow, 1);
      chk("drop_count4", fifo_count, 4);
      tp_ready = 1'b1;
      wb(5'd13, 32'h66);
      tp_ready = 1'b0;
      chk("pp_full_count", fifo_count, 4);
      chk("pp_full_drop", drop_count, 1);
      chk("pp_full_head", tp_reg, 17);
      chk("pp_full_data", tp_data, 32'h55);

      tp_ready = 1'b1;
      tick(); chk("drain_15", tp_reg, 15);
      tick(); chk("drain_16", tp_data, 32'hA2);
      tick(); chk("drain_13", tp_data, 32'h66);
      tick(); chk("drain_empty", tp_valid, 0);
      chk("drain_count", fifo_count, 0);
      tick(); chk("empty_nopop", fifo_count, 0);
      tp_ready = 1'b0;
      chk("ovf_sticky", overflow, 1);

      fp_valid = 1; fp_chan = 2; fp_data = 32'hDEADBEEF;
      tick();
      chk("in1_valid", in_valid, 1);
      chk("in1_chan", in_chan, 2);
      chk("in1_data", in_data, 32'hDEADBEEF);
      chk("in1_ready", fp_ready, 0);
      fp_chan = 1; fp_data = 32'h1;
      tick();
      chk("in2_held", in_data, 32'hDEADBEEF);
      in_consume = 1;
      tick();
      chk("in3_data", in_data, 32'h1);
      chk("in3_chan", in_chan, 1);
      chk("in3_valid", in_valid, 1);
      fp_valid = 0;
      tick();
      chk("in4_clear", in_valid, 0);
      chk("in4_keep", in_data, 32'h1);
      tick();
      chk("in5_idle", in_valid, 0);
      in_consume = 0;
      fp_valid = 1; fp_chan = 3; fp_data = 32'hCAFE0000;
      tick();
      fp_valid = 0;
      chk("in6_data", in_data, 32'hCAFE0000);

      wb(5'd10, 32'h1); wb(5'd11, 32'h2); wb(5'd12, 32'h3);
      chk("pre_rst_count", fifo_count, 3);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_valid", tp_valid, 0);
      chk("mid_rst_in", in_valid, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_drop", drop_count, 0);

      l_wb_write = 1; l_wb_reg = 5'd14; l_wb_data = 32'h5A;
      for (int i = 0; i < 102; i++) begin
         tick();
         if (l_stall) stall_seen++;
      end
      chk("lossy_drop100", l_drop, 100);
      chk("lossy_count", l_count, 2);
      for (int i = 0; i < 69898; i++) begin
         tick();
         if (l_stall) stall_seen++;
      end
      l_wb_write = 0;
      chk("lossy_sat", l_drop, 16'hFFFF);
      chk("lossy_ovf", l_overflow, 1);
      chk("lossy_stall", stall_seen, 0);
      chk("lossy_head", l_tp_reg, 14);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_io_bridge.md
Name: core_io_bridge

Overview:
- Parametrised, buffered successor to the single-register writeback-snoop output path of the 5-stage BRISC-V core.
- Snoops the writeback port and captures writes to a configurable register window into an outbound FIFO with a valid/ready handshake to the peripheral.
- Asserts a stall request when the FIFO nears full, and counts any dropped entries.
- Holds one inbound peripheral word in a skid register until the core consumes it.

Parameters:
CORE, 0, core ID carried on every outbound entry
DATA_WIDTH, 32, data width
REG_LO, 10, lowest snooped register index (1..31)
REG_HI, 17, highest snooped register index (REG_LO..31)
FIFO_DEPTH, 4, outbound entries; power of two, >=2
STALL_MARGIN, 2, free-slot threshold for stall_out; 1..FIFO_DEPTH-1
STALL_ON_FULL, 1, 1: stall_out active; 0: stall_out tied 0 (lossy mode)

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high
wb_write  in  1  writeback register-write strobe
wb_reg  in  5  writeback destination register
wb_data  in  DATA_WIDTH  writeback data
to_peripheral_valid  out  1  head entry valid
to_peripheral_ready  in  1  peripheral accepts head
to_peripheral_data  out  DATA_WIDTH  head data
to_peripheral_reg  out  5  head register index
to_peripheral_core  out  8  CORE[7:0]
stall_out  out  1  stall request to the core
from_peripheral  in  2  inbound channel code
from_peripheral_data  in  32  inbound data
from_peripheral_valid  in  1  inbound strobe
from_peripheral_ready  out  1  holding register can accept
in_valid  out  1  inbound word held
in_chan  out  2  held channel code
in_data  out  32  held data
in_consume  in  1  core consumes the held word
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
drop_count  out  16  saturating count of dropped captures
overflow  out  1  sticky; set on first drop

Behaviour:
- Reset:
  - All outputs are 0, except from_peripheral_ready = 1 and to_peripheral_core = CORE.
  - FIFO pointers, count, holding register, drop_count and overflow are cleared.
  - Reset mid-transfer discards all buffered entries.
- Capture:
  - push = wb_write && wb_reg != 0 && REG_LO <= wb_reg <= REG_HI.
  - The entry is {wb_reg, wb_data}, written at the tail on the clock edge.
- Outbound FIFO:
  - First-word-fall-through. to_peripheral_valid = (count != 0), with data and reg driven from the head combinationally from registers.
  - pop = to_peripheral_valid && to_peripheral_ready.
  - Latency: a push at edge N is visible on to_peripheral_* after edge N when the FIFO was empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Valid/data stay stable while ready = 0.
- Simultaneous events:
  - push && pop when not full: count unchanged; entry order preserved.
  - push && pop when full: push accepted; count stays FIFO_DEPTH.
  - push && !pop when full: entry dropped, drop_count += 1 (saturates at 0xFFFF), overflow <= 1. Overflow clears only on reset.
  - pop when empty: impossible, because valid = 0.
- Stall:
  - stall_out = STALL_ON_FULL && (FIFO_DEPTH - count) < STALL_MARGIN.
  - Registered-count based, i.e. combinational from the current count; no dependency on same-cycle push or pop.
  - STALL_MARGIN covers writebacks already in flight past decode.
- Inbound holding register:
  - from_peripheral_ready = !in_valid || in_consume.
  - On from_peripheral_valid && from_peripheral_ready: latch chan and data, in_valid <= 1.
  - Otherwise, in_consume && in_valid clears in_valid. in_data and in_chan retain their values after a clear.
  - Consume and new arrival in the same cycle: the new word replaces the old; in_valid stays 1.
  - in_consume while in_valid = 0 is ignored.
- Parameter violations (non-power-of-two depth, REG_LO > REG_HI, bad margin) are caught with an $error at elaboration.

Test Plan:
- Reset with to_peripheral_ready = 0, then write x10 = 0x11, x11 = 0x22, x5 = 0x33 (outside the window), x0 -> fifo_count = 2; head shows reg 10, data 0x11; x5 and x0 are not captured.
- With DEPTH 4 and MARGIN 2, push 3 entries while ready = 0 -> stall_out rises when count = 3. Raise ready for 1 cycle -> head becomes reg 11, count = 2, stall_out falls.
- Fill to 4, push x12 = 0x44 with ready = 0 -> drop_count = 1, overflow = 1, count = 4. Repeat with ready = 1 in the same cycle -> accepted, no drop.
- STALL_ON_FULL = 0, DEPTH 2: 70000 pushes with ready = 0 -> stall_out stays 0, drop_count saturates at 0xFFFF.
- Inbound: valid with chan 2, data 0xDEADBEEF -> in_valid = 1, ready = 0. Second word 0x1 without consume -> held. Assert consume and valid together -> in_data = 0x1, in_valid stays 1.
- Assert reset with 3 entries queued and an inbound word held -> next cycle count = 0, to_peripheral_valid = 0, in_valid = 0, overflow = 0.
